apb_master: RTL and testbench

//  APB initiator for the UART configuration/status bus. Takes single-beat

---
 rtl/apb_master.sv | 170 +++++++++++++++++
 tb/tb_apb_master.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB initiator: one single-beat local request becomes one APB transfer, answered by a one-cycle response strobe.
// Optional access timeout is enabled by defining APB_MASTER_TIMEOUT_EN (limit set by TIMEOUT).
module apb_master #(
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("apb_master: TIMEOUT must be at least 1");
    end

    state_t              state_q, state_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rsp_to_q, rsp_to_d;
`endif

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_to_d    = rsp_to_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = req_write;
                    paddr_d   = req_addr;
                    pwdata_d  = req_write ? req_wdata : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                // pready wins over a timeout that expires in the same cycle
                if (pready) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    pwrite_d    = 1'b0;
                    paddr_d     = '0;
                    pwdata_d    = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
`ifdef APB_MASTER_TIMEOUT_EN
                    rsp_to_d    = 1'b0;
                end else if (cnt_q == LIMIT) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    pwrite_d    = 1'b0;
                    paddr_d     = '0;
                    pwdata_d    = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_to_d    = 1'b1;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_to_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_to_q    <= rsp_to_d;
`endif
        end
    end

    assign req_ready = (state_q == IDLE);
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    assign rsp_timeout = rsp_to_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed vector table, multi-cycle corner sequences and random transfers
// checked against a transaction-level model of latency, bus phases and response contents.
module tb_apb_master;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_write;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_err, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic       psel, penable, pwrite;
    logic [2:0] paddr;
    logic [7:0] pwdata, prdata;
    logic       pready, pslverr;

    int total = 0;
    int bad   = 0;

    apb_master #(.ADDR_W(3), .DATA_W(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] wdata;
        int         waits;
        logic [7:0] rdata;
        logic       slverr;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         exp_lat;
        int         exp_en;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level view: latency counts from the accept edge to the strobe.
    task automatic model(input logic wr, input int waits, input logic [7:0] rd, input logic err,
                         output logic [7:0] erd, output logic eerr, output logic eto,
                         output int lat, output int en);
`ifdef APB_MASTER_TIMEOUT_EN
        if (waits >= TO) begin
            erd = 8'h00; eerr = 1'b1; eto = 1'b1; lat = 2 + TO; en = TO;
            return;
        end
`endif
        erd  = wr ? 8'h00 : rd;
        eerr = err;
        eto  = 1'b0;
        lat  = 3 + waits;
        en   = waits + 1;
    endtask

    task automatic xfer(input logic wr, input logic [2:0] a, input logic [7:0] wd, input int waits,
                        input logic [7:0] rd, input logic err,
                        input logic [7:0] erd, input logic eerr, input logic eto,
                        input int lat, input int en);
        int   cyc = 1;
        int   en_cnt = 0;
        logic done = 1'b0;
        logic proto_ok = 1'b1;
        logic [7:0] exp_wd;
        exp_wd = wr ? wd : 8'h00;
        @(negedge clk);
        check("req_ready_idle", {31'b0, req_ready}, 1);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; pready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom); req_addr = 3'($urandom); req_wdata = 8'($urandom);
        while (!done && cyc < 200) begin
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                if (psel !== 1'b1 || pwrite !== wr || paddr !== a || pwdata !== exp_wd) proto_ok = 1'b0;
                if (cyc == 1 && penable !== 1'b0) proto_ok = 1'b0;
                if (cyc > 1) begin
                    if (penable !== 1'b1) proto_ok = 1'b0;
                    en_cnt++;
                    pready = (en_cnt > waits);
                end
                prdata  = pready ? rd : ~rd;
                pslverr = pready ? err : ~err;
                @(negedge clk);
                cyc++;
            end
        end
        check("rsp_seen", {31'b0, done}, 1);
        check("latency", cyc, lat);
        check("penable_cycles", en_cnt, en);
        check("bus_stable", {31'b0, proto_ok}, 1);
        check("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, erd});
        check("rsp_err", {31'b0, rsp_err}, {31'b0, eerr});
        check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, eto});
        check("resp_bus_idle", {17'b0, psel, penable, pwrite, paddr, pwdata}, 0);
        check("resp_not_ready", {31'b0, req_ready}, 0);
        pready = 1'b0; prdata = 8'($urandom); pslverr = 1'($urandom);
        @(negedge clk);
        check("strobe_one_cycle", {31'b0, rsp_valid}, 0);
        check("rsp_hold", {22'b0, rsp_rdata, rsp_err, rsp_timeout}, {22'b0, erd, eerr, eto});
        check("ready_after_resp", {31'b0, req_ready}, 1);
    endtask

    task automatic run_model(input logic wr, input logic [2:0] a, input logic [7:0] wd,
                             input int waits, input logic [7:0] rd, input logic err);
        logic [7:0] erd;
        logic       eerr, eto;
        int         lat, en;
        model(wr, waits, rd, err, erd, eerr, eto, lat, en);
        xfer(wr, a, wd, waits, rd, err, erd, eerr, eto, lat, en);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1'b1, 3'd2, 8'hA5, 0, 8'h5A, 1'b0, 8'h00, 1'b0, 3, 1};
        vecs[1] = '{1'b0, 3'd6, 8'h11, 0, 8'h3C, 1'b0, 8'h3C, 1'b0, 3, 1};
        vecs[2] = '{1'b1, 3'd0, 8'h77, 0, 8'hFF, 1'b1, 8'h00, 1'b1, 3, 1};
        vecs[3] = '{1'b0, 3'd1, 8'h00, 3, 8'h96, 1'b0, 8'h96, 1'b0, 6, 4};
        vecs[4] = '{1'b0, 3'd7, 8'hEE, 2, 8'hC3, 1'b1, 8'hC3, 1'b1, 5, 3};

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        #12;
        check("reset_ready", {31'b0, req_ready}, 1);
        check("reset_outputs", {10'b0, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
                                psel, penable, pwrite, paddr, pwdata}, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i])
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].rdata,
                 vecs[i].slverr, vecs[i].exp_rdata, vecs[i].exp_err, 1'b0,
                 vecs[i].exp_lat, vecs[i].exp_en);

        // Timeout boundary: ready on the last allowed cycle, then stuck low.
        run_model(1'b0, 3'd3, 8'h00, TO - 1, 8'h81, 1'b0);
        run_model(1'b0, 3'd4, 8'h00, TO, 8'h42, 1'b0);
        run_model(1'b1, 3'd5, 8'h99, TO + 4, 8'h42, 1'b0);

        // Reset in the middle of an ACCESS phase with pready held low.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd5; pready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_access", {30'b0, psel, penable}, 3);
        #2 rst = 1'b1;
        #1;
        check("async_reset_bus", {29'b0, psel, penable, rsp_valid}, 0);
        check("async_reset_ready", {31'b0, req_ready}, 1);
        @(negedge clk);
        rst = 1'b0;
        begin
            logic stray = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (rsp_valid) stray = 1'b1;
            end
            check("no_rsp_after_abort", {31'b0, stray}, 0);
        end
        run_model(1'b1, 3'd6, 8'h5C, 0, 8'h00, 1'b0);

        for (int n = 0; n < 30; n++) begin
            run_model(1'($urandom), 3'($urandom), 8'($urandom), int'($urandom_range(0, 5)),
                      8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
